instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  IF stage: generates PC, fetches instruction words from instruction memory and presents
//  {instr, pc} to the ID-stage decoder (opcode/funct source for the control unit).
//  Consumes the ID stage's branch/jump resolution as a redirect. A 2-entry buffer decouples
//  memory latency from ID stalls. At most one memory request is outstanding.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC loaded on reset
//  BUF_DEPTH  2              instruction buffer entries (fixed at 2; other values unsupported)
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   asynchronous active-low reset
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch address, word aligned
//  imem_ready      in   1   memory accepts request this cycle
//  imem_rvalid     in   1   read data valid (>=1 cycle after accept, in order)
//  imem_rdata      in   32  instruction word
//  id_valid        out  1   buffer head valid toward ID
//  id_instr        out  32  head instruction ([31:26] opcode, [5:0] funct)
//  id_pc           out  32  PC of head instruction
//  id_ready        in   1   ID consumes head (low = hazard stall)
//  redirect_valid  in   1   taken branch/jump resolved in ID
//  redirect_pc     in   32  target; bits [1:0] ignored (treated as 00)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=RUN, outstanding=0, buffer empty; imem_req=0, id_valid=0,
//   id_instr=0, id_pc=0, imem_addr=RESET_PC.
//  FSM: RUN (normal) / DRAIN (one stale response pending, discard it).
//  imem_req = state==RUN && !outstanding && (count<2) && !redirect_valid; imem_addr = pc.
//  Accept (imem_req && imem_ready): outstanding<=1, fetch_pc<=pc, pc<=pc+4 (32-bit wrap,
//   FFFF_FFFC -> 0000_0000).
//  Response (imem_rvalid && outstanding): outstanding<=0; in RUN push {imem_rdata, fetch_pc};
//   in DRAIN discard, state<=RUN. imem_rvalid with outstanding=0 is ignored.
//  id_valid = count!=0; head popped on id_valid && id_ready. Push+pop same cycle: count unchanged.
//   Buffer never overflows: request gated on count<2 with <=1 in flight.
//  Redirect (highest priority): buffer flushed (id_valid=0 next cycle), pc<=redirect_pc & ~3.
//   Outstanding and no response this cycle -> state<=DRAIN. Response in the same cycle as the
//   redirect is dropped, outstanding<=0, state stays RUN. A pop that coincides with the redirect
//   is still a valid consume by ID.
//  Latency (1-cycle memory, id_ready=1): redirect at N -> req @N+1 -> rvalid @N+2 -> id_valid @N+3.
//   Steady state: one instruction per 2 cycles (single outstanding request).
//  Reset asserted mid-operation: all state cleared immediately. Late responses after release are
//   ignored (outstanding=0).
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs perf_fetch_cnt[31:0] (instructions pushed) and
//   perf_stall_cnt[31:0] (cycles id_valid && !id_ready). Both reset to 0 and wrap.
//  Not defined: ports and counters absent; no other behavioural change.
// TESTING
//  Reset release, 1-cycle mem, id_ready=1 -> imem_addr 3000,3004,3008...; id_pc follows in order.
//  id_ready=0 for 10 cycles -> buffer fills to 2, imem_req=0, head instr/pc held stable.
//  Redirect to 0x0000_3100 while request outstanding (rvalid delayed 3) -> stale word dropped,
//   next id_pc=3100.
//  redirect_pc=0x0000_3102 -> imem_addr=3100; redirect coincident with rvalid -> word not pushed.
//  RESET_PC=FFFF_FFF8 -> fetch addrs FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  IF_PERF_CNT_EN: 8 fetches and 5 stall cycles -> perf_fetch_cnt=8, perf_stall_cnt=5.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage with PC, single-outstanding imem fetch, 2-entry buffer toward ID.
// Optional IF_PERF_CNT_EN adds perf_fetch_cnt/perf_stall_cnt outputs.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef IF_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, fetch_pc_q;
  logic        out_q, out_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] instr_q [2];
  logic [31:0] bpc_q [2];
  logic        accept, resp, push, pop, wr_idx;
  assign imem_req  = rst_n && state_q == RUN && !out_q && count_q < 2'(BUF_DEPTH) && !redirect_valid;
  assign imem_addr = pc_q;
  assign id_valid  = count_q != 2'd0;
  assign id_instr  = instr_q[0];
  assign id_pc     = bpc_q[0];
  assign accept    = imem_req && imem_ready;
  assign resp      = imem_rvalid && out_q;
  assign pop       = id_valid && id_ready;
  assign push      = resp && state_q == RUN && !redirect_valid;
  // Slot written after any same-cycle pop has shifted the head out.
  assign wr_idx    = pop ? count_q[1] : count_q[0];
  always_comb begin
    state_d = redirect_valid ? ((out_q && !resp) ? DRAIN : RUN) : (resp ? RUN : state_q);
    out_d   = resp ? 1'b0 : (accept ? 1'b1 : out_q);
    pc_d    = redirect_valid ? (redirect_pc & ~32'd3) : (accept ? pc_q + 32'd4 : pc_q);
    count_d = redirect_valid ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      out_q      <= 1'b0;
      count_q    <= 2'd0;
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      bpc_q[0]   <= '0;
      bpc_q[1]   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      count_q <= count_d;
      if (accept) fetch_pc_q <= pc_q;
      if (pop) begin
        instr_q[0] <= instr_q[1];
        bpc_q[0]   <= bpc_q[1];
      end
      if (push) begin
        instr_q[wr_idx] <= imem_rdata;
        bpc_q[wr_idx]   <= fetch_pc_q;
      end
    end
  end
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(push);
      stall_cnt_q <= stall_cnt_q + 32'(id_valid && !id_ready);
    end
  end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven directed checks of instr_fetch_unit (default and wrapping RESET_PC).
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1, rst2_n = 1'b0;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0, id_ready = 1'b1, redirect_valid = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic        imem_req, id_valid, w_req, w_idv;
  logic [31:0] imem_addr, id_instr, id_pc, w_addr, w_instr, w_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] pf, ps, wpf, wps;
`endif
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(pf), .perf_stall_cnt(ps),
`endif
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst2_n),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(wpf), .perf_stall_cnt(wps),
`endif
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(w_idv), .id_instr(w_instr), .id_pc(w_pc), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc));

  typedef struct {
    logic rdy, rv;
    logic [31:0] rdata;
    logic idr, rdv;
    logic [31:0] rpc;
    logic req;
    logic [31:0] addr;
    logic idv;
    logic [31:0] instr, pc;
  } vec_t;

  vec_t tbl [33];
  vec_t wtbl [5];

  function automatic vec_t mk(logic rdy, logic rv, logic [31:0] rdata, logic idr, logic rdv,
                              logic [31:0] rpc, logic req, logic [31:0] addr, logic idv,
                              logic [31:0] instr, logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.idr = idr; v.rdv = rdv; v.rpc = rpc;
    v.req = req; v.addr = addr; v.idv = idv; v.instr = instr; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input bit sel, input int idx);
    @(negedge clk);
    imem_ready = v.rdy; imem_rvalid = v.rv; imem_rdata = v.rdata;
    id_ready = v.idr; redirect_valid = v.rdv; redirect_pc = v.rpc;
    #1;
    chk($sformatf("%s%0d req", sel ? "wrap" : "row", idx), 32'(sel ? w_req : imem_req), 32'(v.req));
    chk($sformatf("%s%0d addr", sel ? "wrap" : "row", idx), sel ? w_addr : imem_addr, v.addr);
    chk($sformatf("%s%0d id_valid", sel ? "wrap" : "row", idx), 32'(sel ? w_idv : id_valid), 32'(v.idv));
    if (v.idv) begin
      chk($sformatf("%s%0d id_instr", sel ? "wrap" : "row", idx), sel ? w_instr : id_instr, v.instr);
      chk($sformatf("%s%0d id_pc", sel ? "wrap" : "row", idx), sel ? w_pc : id_pc, v.pc);
    end
  endtask

  initial begin
    // Main instance: fetch, stall, redirects, drain, coincident redirect+response.
    tbl[0]  = mk(1, 0, 0,            1, 0, 0,     1, 32'h3000, 0, 0, 0);
    tbl[1]  = mk(1, 1, 32'hC0DE3000, 1, 0, 0,     0, 32'h3004, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0,            1, 0, 0,     1, 32'h3004, 1, 32'hC0DE3000, 32'h3000);
    tbl[3]  = mk(1, 1, 32'hC0DE3004, 1, 0, 0,     0, 32'h3008, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0,            1, 0, 0,     1, 32'h3008, 1, 32'hC0DE3004, 32'h3004);
    tbl[5]  = mk(1, 1, 32'hC0DE3008, 1, 0, 0,     0, 32'h300C, 0, 0, 0);
    tbl[6]  = mk(1, 0, 0,            0, 0, 0,     1, 32'h300C, 1, 32'hC0DE3008, 32'h3008);
    tbl[7]  = mk(1, 1, 32'hC0DE300C, 0, 0, 0,     0, 32'h3010, 1, 32'hC0DE3008, 32'h3008);
    for (int i = 8; i < 16; i++)
      tbl[i] = mk(1, 0, 0,           0, 0, 0,     0, 32'h3010, 1, 32'hC0DE3008, 32'h3008);
    tbl[16] = mk(1, 0, 0,            1, 0, 0,     0, 32'h3010, 1, 32'hC0DE3008, 32'h3008);
    tbl[17] = mk(1, 0, 0,            1, 0, 0,     1, 32'h3010, 1, 32'hC0DE300C, 32'h300C);
    tbl[18] = mk(1, 1, 32'hC0DE3010, 1, 0, 0,     0, 32'h3014, 0, 0, 0);
    tbl[19] = mk(1, 0, 0,            1, 1, 32'h3102, 0, 32'h3014, 1, 32'hC0DE3010, 32'h3010);
    tbl[20] = mk(0, 1, 32'h0BAD0BAD, 1, 0, 0,     1, 32'h3100, 0, 0, 0);
    tbl[21] = mk(1, 0, 0,            1, 0, 0,     1, 32'h3100, 0, 0, 0);
    tbl[22] = mk(1, 0, 0,            1, 0, 0,     0, 32'h3104, 0, 0, 0);
    tbl[23] = mk(1, 0, 0,            1, 1, 32'h3200, 0, 32'h3104, 0, 0, 0);
    tbl[24] = mk(1, 0, 0,            1, 0, 0,     0, 32'h3200, 0, 0, 0);
    tbl[25] = mk(1, 1, 32'hDEADBEEF, 1, 0, 0,     0, 32'h3200, 0, 0, 0);
    tbl[26] = mk(1, 0, 0,            1, 0, 0,     1, 32'h3200, 0, 0, 0);
    tbl[27] = mk(1, 1, 32'hC0DE3200, 1, 0, 0,     0, 32'h3204, 0, 0, 0);
    tbl[28] = mk(1, 0, 0,            1, 0, 0,     1, 32'h3204, 1, 32'hC0DE3200, 32'h3200);
    tbl[29] = mk(1, 1, 32'hC0DE3204, 1, 1, 32'h3100, 0, 32'h3208, 0, 0, 0);
    tbl[30] = mk(1, 0, 0,            1, 0, 0,     1, 32'h3100, 0, 0, 0);
    tbl[31] = mk(1, 1, 32'hC0DE3100, 1, 0, 0,     0, 32'h3104, 0, 0, 0);
    tbl[32] = mk(1, 0, 0,            1, 0, 0,     1, 32'h3104, 1, 32'hC0DE3100, 32'h3100);
    // Second instance: PC wraps past the top of the address space.
    wtbl[0] = mk(1, 0, 0,            1, 0, 0,     1, 32'hFFFF_FFF8, 0, 0, 0);
    wtbl[1] = mk(1, 1, 32'h11111111, 1, 0, 0,     0, 32'hFFFF_FFFC, 0, 0, 0);
    wtbl[2] = mk(1, 0, 0,            1, 0, 0,     1, 32'hFFFF_FFFC, 1, 32'h11111111, 32'hFFFF_FFF8);
    wtbl[3] = mk(1, 1, 32'h22222222, 1, 0, 0,     0, 32'h0000_0000, 0, 0, 0);
    wtbl[4] = mk(1, 0, 0,            1, 0, 0,     1, 32'h0000_0000, 1, 32'h22222222, 32'hFFFF_FFFC);

    #1 rst_n = 1'b0;
    #1;
    chk("reset req", 32'(imem_req), 32'd0);
    chk("reset addr", imem_addr, 32'h3000);
    chk("reset id_valid", 32'(id_valid), 32'd0);
    chk("reset id_instr", id_instr, 32'd0);
    chk("reset id_pc", id_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 33; i++) apply(tbl[i], 1'b0, i);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_cnt", pf, 32'd7);
    chk("perf_stall_cnt", ps, 32'd10);
`endif
    // Reset asserted mid-cycle with a request outstanding.
    @(negedge clk);
    imem_ready = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst req", 32'(imem_req), 32'd0);
    chk("midrst addr", imem_addr, 32'h3000);
    chk("midrst id_valid", 32'(id_valid), 32'd0);
    chk("midrst id_instr", id_instr, 32'd0);
    chk("midrst id_pc", id_pc, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("midrst perf_fetch", pf, 32'd0);
    chk("midrst perf_stall", ps, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0BADF00D;
    #1;
    chk("late req", 32'(imem_req), 32'd1);
    chk("late addr", imem_addr, 32'h3000);
    chk("late id_valid", 32'(id_valid), 32'd0);
    @(negedge clk);
    imem_rvalid = 1'b0; rst2_n = 1'b1;
    #1;
    chk("late ignored id_valid", 32'(id_valid), 32'd0);
    for (int i = 0; i < 5; i++) apply(wtbl[i], 1'b1, i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
